// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the multi-cycle divide controller.
//   div_state_e  : controller FSM states (IDLE, CALC, DONE)
//   HILO_WE_*    : HI/LO write-enable encodings, bit 1 = HI, bit 0 = LO
//   DIV*_FUNCT   : SPECIAL-opcode funct codes the decoder matches to raise start_i
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    localparam logic [1:0] HILO_WE_NONE = 2'b00;
    localparam logic [1:0] HILO_WE_HI   = 2'b10;
    localparam logic [1:0] HILO_WE_LO   = 2'b01;
    localparam logic [1:0] HILO_WE_BOTH = 2'b11;

    localparam logic [5:0] DIV_FUNCT  = 6'h1A;
    localparam logic [5:0] DIVU_FUNCT = 6'h1B;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration (purely combinational).
//   rem_i     : partial remainder before the step
//   quo_i     : quotient register; its MSB is the next dividend bit to shift in
//   divisor_i : divisor magnitude
//   rem_o     : partial remainder after the step
//   quo_o     : quotient register shifted left with the new quotient bit in the LSB
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    // Shift the next dividend bit into the remainder. One extra bit is needed
    // because the shifted remainder can reach 2*divisor-1.
    logic [WIDTH:0] shifted;
    logic           fits;

    assign shifted = {rem_i, quo_i[WIDTH-1]};
    assign fits    = (shifted >= {1'b0, divisor_i});

    // When the subtraction fits, the difference is below the divisor, so it
    // always fits back into WIDTH bits.
    assign rem_o = fits ? WIDTH'(shifted - {1'b0, divisor_i}) : shifted[WIDTH-1:0];
    assign quo_o = {quo_i[WIDTH-2:0], fits};

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU controller for the EX stage.
//   clk, resetn : clock, synchronous active-low reset
//   start_i     : DIV/DIVU in EX (held while stall_o is high)
//   signed_i    : 1 = DIV, 0 = DIVU, sampled with start_i
//   opa_i/opb_i : dividend (rs) / divisor (rt)
//   flush_i     : EX flush, aborts any operation without writing HI/LO
//   stall_o     : freeze IF/ID/EX
//   hilo_we_o   : 2'b11 for the single DONE cycle, else 2'b00
//   hi_o/lo_o   : registered remainder / quotient
//   busy_o      : controller not idle
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic [1:0]       hilo_we_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic             sgn_q, sgn_d, neg_a_q, neg_a_d, neg_b_q, neg_b_d;

    logic [WIDTH-1:0] step_rem, step_quo;
    logic             a_neg, b_neg;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i    (rem_q),
        .quo_i    (quo_q),
        .divisor_i(dvs_q),
        .rem_o    (step_rem),
        .quo_o    (step_quo)
    );

    assign a_neg = signed_i & opa_i[WIDTH-1];
    assign b_neg = signed_i & opb_i[WIDTH-1];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        sgn_d   = sgn_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;

        unique case (state_q)
            DIV_IDLE: begin
                if (start_i) begin
                    // Dividend goes into the quotient register and is shifted
                    // out MSB-first while quotient bits shift in at the LSB.
                    quo_d   = a_neg ? -opa_i : opa_i;
                    dvs_d   = b_neg ? -opb_i : opb_i;
                    rem_d   = '0;
                    cnt_d   = '0;
                    sgn_d   = signed_i;
                    neg_a_d = a_neg;
                    neg_b_d = b_neg;
                    if (opb_i == '0) begin
                        // Divide by zero skips CALC; the raw dividend is the remainder.
                        state_d = DIV_DONE;
                        hi_d    = opa_i;
                        lo_d    = '1;
                    end else begin
                        state_d = DIV_CALC;
                    end
                end
            end
            DIV_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = DIV_DONE;
                    // Sign fix-up: quotient sign follows sign(a)^sign(b),
                    // remainder sign follows the dividend.
                    lo_d = (sgn_q && (neg_a_q ^ neg_b_q)) ? -step_quo : step_quo;
                    hi_d = (sgn_q && neg_a_q) ? -step_rem : step_rem;
                end
            end
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase

        // A flush overrides everything: back to IDLE, results untouched.
        if (flush_i) begin
            state_d = DIV_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // NOTE: the datapath registers are deliberately not reset; they are
    // always loaded in IDLE before they are read, so a reset would only
    // cost routing.
    always_ff @(posedge clk) begin
        rem_q   <= rem_d;
        quo_q   <= quo_d;
        dvs_q   <= dvs_d;
        sgn_q   <= sgn_d;
        neg_a_q <= neg_a_d;
        neg_b_q <= neg_b_d;
    end

    // Stall is low in DONE so the retiring instruction advances in the same
    // cycle HI/LO is written.
    assign stall_o   = !flush_i && ((state_q == DIV_IDLE && start_i) || state_q == DIV_CALC);
    assign hilo_we_o = (state_q == DIV_DONE && !flush_i) ? HILO_WE_BOTH : HILO_WE_NONE;
    assign busy_o    = (state_q != DIV_IDLE);
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: the driver pushes expected results, a
// negedge monitor pops and compares whenever the DUT writes HI/LO.
module tb_div_ctrl;
    import div_ctrl_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         resetn;
    logic         start_i;
    logic         signed_i;
    logic [W-1:0] opa_i;
    logic [W-1:0] opb_i;
    logic         flush_i;
    logic         stall_o;
    logic [1:0]   hilo_we_o;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;
    logic         busy_o;

    div_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start_i  (start_i),
        .signed_i (signed_i),
        .opa_i    (opa_i),
        .opb_i    (opb_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .hilo_we_o(hilo_we_o),
        .hi_o     (hi_o),
        .lo_o     (lo_o),
        .busy_o   (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           issue;
        int           lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: MIPS DIV/DIVU truncating division, results modulo 2^W.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                                  output logic [W-1:0] hi, output logic [W-1:0] lo);
        longint da, db;
        if (b == '0) begin
            hi = a;
            lo = '1;
        end else if (s) begin
            da = longint'($signed(a));
            db = longint'($signed(b));
            lo = W'(da / db);
            hi = W'(da % db);
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endfunction

    // Monitor: every HI/LO write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (hilo_we_o !== HILO_WE_NONE) begin
            if (sb.size() == 0) begin
                check("unexpected_write", {62'd0, hilo_we_o}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("hilo_we", {62'd0, hilo_we_o}, 64'd3);
                check("hi", {32'd0, hi_o}, {32'd0, mon_e.hi});
                check("lo", {32'd0, lo_o}, {32'd0, mon_e.lo});
                check("latency", 64'(cyc - mon_e.issue), 64'(mon_e.lat));
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the edge that ends DONE
    // with start_i still high (the retiring instruction is still in EX).
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                           input logic [W-1:0] hi, input logic [W-1:0] lo);
        exp_t e;
        int   stalls = 0;
        bit   seen   = 0;
        start_i  = 1'b1;
        signed_i = s;
        opa_i    = a;
        opb_i    = b;
        e.hi     = hi;
        e.lo     = lo;
        e.issue  = cyc;
        e.lat    = (b == '0) ? 1 : W + 1;
        sb.push_back(e);
        for (int i = 0; i < W + 8 && !seen; i++) begin
            @(negedge clk);
            if (stall_o) stalls++;
            if (hilo_we_o == HILO_WE_BOTH) seen = 1;
        end
        check("done_seen", 64'(seen), 64'd1);
        check("stall_cycles", 64'(stalls), 64'(e.lat));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        start_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 6))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return W'($urandom_range(0, 20));
            4:       return -W'($urandom_range(1, 20));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int           c0;
        logic [W-1:0] a, b, mh, ml;
        bit           s;

        resetn   = 1'b0;
        start_i  = 1'b0;
        signed_i = 1'b0;
        opa_i    = '0;
        opb_i    = '0;
        flush_i  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hi", {32'd0, hi_o}, 64'd0);
        check("rst_lo", {32'd0, lo_o}, 64'd0);
        check("rst_we", {62'd0, hilo_we_o}, 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_stall", 64'(stall_o), 64'd0);
        resetn = 1'b1;
        idle(2);

        // Directed cases, some back-to-back (start accepted right after DONE).
        run_div(32'd100, 32'd7, 1'b0, 32'd2, 32'd14);
        idle(1);
        run_div(32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFF2);
        run_div(32'd100, 32'hFFFF_FFF9, 1'b1, 32'd2, 32'hFFFF_FFF2);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000);
        run_div(32'd5, 32'd0, 1'b0, 32'd5, 32'hFFFF_FFFF);
        run_div(32'hFFFF_FFF0, 32'd0, 1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
        idle(2);

        // Flush mid-divide at cycle 10, then a fresh DIVU 9/3 at cycle 11.
        c0       = cyc;
        start_i  = 1'b1;
        signed_i = 1'b0;
        opa_i    = 32'd1234;
        opb_i    = 32'd5;
        repeat (10) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(negedge clk);
        check("flush_stall", 64'(stall_o), 64'd0);
        check("flush_we", {62'd0, hilo_we_o}, 64'd0);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        check("flush_idle", 64'(busy_o), 64'd0);
        check("flush_restart_cycle", 64'(cyc - c0), 64'd11);
        run_div(32'd9, 32'd3, 1'b0, 32'd0, 32'd3);
        idle(2);

        // Flush landing on the DONE cycle of a divide by zero: no write.
        start_i  = 1'b1;
        signed_i = 1'b0;
        opa_i    = 32'd5;
        opb_i    = 32'd0;
        @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(negedge clk);
        check("flush_done_we", {62'd0, hilo_we_o}, 64'd0);
        check("flush_done_stall", 64'(stall_o), 64'd0);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        start_i = 1'b0;
        check("flush_done_idle", 64'(busy_o), 64'd0);
        idle(2);

        // Make HI/LO nonzero, then reset mid-divide at cycle 20.
        run_div(32'd77, 32'd10, 1'b0, 32'd7, 32'd7);
        idle(1);
        start_i  = 1'b1;
        signed_i = 1'b1;
        opa_i    = 32'd1000;
        opb_i    = 32'd3;
        repeat (20) @(posedge clk);
        #1;
        resetn  = 1'b0;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_hi", {32'd0, hi_o}, 64'd0);
        check("mid_rst_lo", {32'd0, lo_o}, 64'd0);
        check("mid_rst_we", {62'd0, hilo_we_o}, 64'd0);
        check("mid_rst_busy", 64'(busy_o), 64'd0);
        check("mid_rst_stall", 64'(stall_o), 64'd0);
        resetn = 1'b1;
        idle(W + 5);

        // Randomized signed/unsigned traffic against the reference model.
        for (int n = 0; n < 1500; n++) begin
            a = rand_op();
            b = rand_op();
            s = 1'($urandom_range(0, 1));
            model(a, b, s, mh, ml);
            run_div(a, b, s, mh, ml);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end

        idle(4);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
